smooth_ctrl: RTL and testbench

- Raster-scan sequencer for the 5x5 Gaussian smoothing datapath.
- Accepts one 5-pixel column per cycle from the line-buffer front end (upstream of the datapath) and tracks the raster position (x, y).
- Decides which datapath outputs are genuine full-window results and tags them with image coordinates.
- Drains the datapath pipeline at frame end and signals frame completion to the feature-extraction stage.

---
 rtl/smooth_ctrl.sv | 168 ++++++++++++++++
 tb/tb_smooth_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/smooth_ctrl.sv
// Raster-scan sequencer for the 5x5 smoothing datapath: tracks (x, y), tags full-window outputs, drains at frame end.
// Optional SMOOTH_BORDER_EN: also tag partial (border) windows and flag them on o_border.
module smooth_ctrl #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int CW       = 12,
    parameter int PIPE_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_out_valid,
    output logic [CW-1:0] o_out_x,
    output logic [CW-1:0] o_out_y,
    output logic          o_border,
    output logic          o_frame_done
);

    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic [2:0]     run_len;
    logic [DCW-1:0] drain_cnt;

    logic accept;
    logic last_col;
    logic last_row;
    logic win_std;
    logic tag_valid;

    // Handshake: a column transfers on a cycle where i_valid and o_ready are both high;
    // i_valid while o_ready is low is dropped and never counted.
    assign accept   = (state == RUN) && i_valid;
    assign last_col = (x == CW'(WIDTH - 1));
    assign last_row = (y == CW'(HEIGHT - 1));
    assign win_std  = accept && (run_len == 3'd4) && (x >= CW'(4)) && (y >= CW'(4));

`ifdef SMOOTH_BORDER_EN
    logic tag_border;
    assign tag_valid  = accept && (run_len >= 3'd2) && (x >= CW'(2)) && (y >= CW'(2));
    assign tag_border = !win_std;
`else
    assign tag_valid  = win_std;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            run_len      <= '0;
            drain_cnt    <= '0;
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= RUN;
                        x       <= '0;
                        y       <= '0;
                        run_len <= '0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        if (x == '0) begin
                            run_len <= 3'd1;
                        end else if (run_len != 3'd4) begin
                            run_len <= run_len + 3'd1;
                        end
                        if (last_col) begin
                            x <= '0;
                            if (last_row) begin
                                y         <= '0;
                                state     <= DRAIN;
                                drain_cnt <= DCW'(PIPE_LAT - 1);
                                o_ready   <= 1'b0;
                            end else begin
                                y <= y + CW'(1);
                            end
                        end else begin
                            x <= x + CW'(1);
                        end
                    end else begin
                        // The datapath shifted a stale column in; the window must refill.
                        run_len <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state        <= DONE;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                DONE: begin
                    o_frame_done <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [PIPE_LAT-1:0] pipe_valid;
    logic [CW-1:0]       pipe_x [PIPE_LAT];
    logic [CW-1:0]       pipe_y [PIPE_LAT];
`ifdef SMOOTH_BORDER_EN
    logic [PIPE_LAT-1:0] pipe_border;
`endif

    // Tags ride alongside the datapath, one stage per clock regardless of state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
`ifdef SMOOTH_BORDER_EN
            pipe_border <= '0;
`endif
        end else begin
            pipe_valid[0] <= tag_valid;
            pipe_x[0]     <= x - CW'(2);
            pipe_y[0]     <= y - CW'(2);
`ifdef SMOOTH_BORDER_EN
            pipe_border[0] <= tag_valid && tag_border;
`endif
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_x[i]     <= pipe_x[i-1];
                pipe_y[i]     <= pipe_y[i-1];
`ifdef SMOOTH_BORDER_EN
                pipe_border[i] <= pipe_border[i-1];
`endif
            end
        end
    end

    assign o_out_valid = pipe_valid[PIPE_LAT-1];
    assign o_out_x     = pipe_x[PIPE_LAT-1];
    assign o_out_y     = pipe_y[PIPE_LAT-1];
`ifdef SMOOTH_BORDER_EN
    assign o_border    = pipe_border[PIPE_LAT-1];
`else
    assign o_border    = 1'b0;
`endif

endmodule

// File: tb/tb_smooth_ctrl.sv
// Bench for smooth_ctrl on an 8x6 image: directed frames, tag/done/status scoreboards checked by a negedge monitor.
module tb_smooth_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 12;
  localparam int PL = 2;
  localparam int EW = 32 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          out_valid;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          border;
  logic          frame_done;

  smooth_ctrl #(.WIDTH(W), .HEIGHT(H), .CW(CW), .PIPE_LAT(PL)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_valid(valid),
    .o_ready(ready),
    .o_busy(busy),
    .o_out_valid(out_valid),
    .o_out_x(out_x),
    .o_out_y(out_y),
    .o_border(border),
    .o_frame_done(frame_done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ready;
    logic        busy;
    logic        ov;
    logic        fd;
    logic        zc;
  } stat_t;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   done_q[$];
  stat_t         stat_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          end_req = 1'b0;
  logic          end_ack = 1'b0;

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0]   dc;
    stat_t         s;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got cyc=%0d x=%0d y=%0d, required no output", cyc, out_x, out_y);
      end else begin
        e = exp_q.pop_front();
        if (e !== {32'(cyc), out_x, out_y} || border !== 1'b0) begin
          errors++;
          $display("FAIL out_tag: got cyc=%0d x=%0d y=%0d border=%0b, required cyc=%0d x=%0d y=%0d border=0",
                   cyc, out_x, out_y, border, e[EW-1:2*CW], e[2*CW-1:CW], e[CW-1:0]);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got frame_done at cyc=%0d, required none", cyc);
      end else begin
        dc = done_q.pop_front();
        if (dc !== 32'(cyc)) begin
          errors++;
          $display("FAIL done_cycle: got cyc=%0d, required cyc=%0d", cyc, dc);
        end
      end
    end
    while (stat_q.size() > 0 && stat_q[0].cyc < 32'(cyc)) begin
      s = stat_q.pop_front();
      checks++;
      errors++;
      $display("FAIL status_missed: status for cyc=%0d not sampled, now cyc=%0d", s.cyc, cyc);
    end
    if (stat_q.size() > 0 && stat_q[0].cyc == 32'(cyc)) begin
      s = stat_q.pop_front();
      checks++;
      if ({ready, busy, out_valid, frame_done} !== {s.ready, s.busy, s.ov, s.fd} ||
          (s.zc && {out_x, out_y, border} !== '0)) begin
        errors++;
        $display("FAIL status: cyc=%0d got rdy=%0b busy=%0b ov=%0b fd=%0b x=%0d y=%0d, required rdy=%0b busy=%0b ov=%0b fd=%0b%s",
                 cyc, ready, busy, out_valid, frame_done, out_x, out_y,
                 s.ready, s.busy, s.ov, s.fd, s.zc ? " x=0 y=0" : "");
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0 || stat_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got pending tags=%0d done=%0d status=%0d, required 0 0 0",
                 exp_q.size(), done_q.size(), stat_q.size());
      end
      end_ack = 1'b1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_stat(input int c, input logic r, input logic b,
                                   input logic ov, input logic fd, input logic zc);
    stat_t s;
    s.cyc   = 32'(c);
    s.ready = r;
    s.busy  = b;
    s.ov    = ov;
    s.fd    = fd;
    s.zc    = zc;
    stat_q.push_back(s);
  endfunction

  // One frame; gap_* inserts an idle cycle before that column, rst_* resets at that column.
  task automatic run_frame(input int gap_row, input int gap_col, input int rst_row, input int rst_col);
    int last_cyc = 0;
    bit aborted  = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    tick();
    start = 1'b0;
    exp_stat(cyc, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < H && !aborted; y++) begin
      for (int x = 0; x < W && !aborted; x++) begin
        if (y == gap_row && x == gap_col) begin
          valid = 1'b0;
          tick();
        end
        if (y == rst_row && x == rst_col) begin
          rst   = 1'b1;
          valid = 1'b1;
          tick();
          rst   = 1'b0;
          valid = 1'b0;
          exp_stat(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          aborted = 1'b1;
        end else begin
          valid = 1'b1;
          start = (y == 1 && x == 3);
          // A gap leaves the window incomplete for the gap column and the three after it.
          if (x >= 4 && y >= 4 && !(y == gap_row && x >= gap_col && x < gap_col + 4))
            exp_q.push_back({32'(cyc + PL), CW'(x - 2), CW'(y - 2)});
          last_cyc = cyc;
          tick();
        end
      end
    end
    valid = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      // first DRAIN cycle still shows the tag of column (6, 5)
      exp_stat(last_cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      done_q.push_back(32'(last_cyc + PL + 1));
      exp_stat(last_cyc + PL + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      while (cyc < last_cyc + PL + 2) tick();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    exp_stat(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      tick();
      exp_stat(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_frame(-1, -1, -1, -1);
    run_frame(-1, -1, -1, -1);
    run_frame(4, 5, -1, -1);
    run_frame(-1, -1, 4, 3);
    run_frame(-1, -1, -1, -1);
    repeat (5) tick();
    end_req = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
